// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_sb
//  Description : Multi-port integer register file with a per-register busy
//                scoreboard. Optional macro RF_WR_BYPASS_EN forwards
//                same-cycle write data to the read ports.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_mp_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NRD*ADDR_W-1:0]     ra,
    output logic [NRD*DATA_W-1:0]     rd_data,
    output logic [NRD-1:0]            rd_busy,
    input  logic [NWR-1:0]            we,
    input  logic [NWR*ADDR_W-1:0]     wa,
    input  logic [NWR*DATA_W-1:0]     wd,
    input  logic                      iss_valid,
    input  logic [ADDR_W-1:0]         iss_rd,
    input  logic                      flush,
    output logic [(1<<ADDR_W)-1:0]    busy_vec
);

    localparam int c_NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [c_NREG];
    logic [c_NREG-1:0] r_busy;

    logic [c_NREG-1:0] w_wr_hit;
    logic [DATA_W-1:0] w_wr_val [c_NREG];
    logic [c_NREG-1:0] w_busy_nxt;

    // Ascending port scan: a later (higher-index) port overwrites an earlier one.
    always_comb begin : write_decode
        for (int k = 0; k < c_NREG; k++) begin
            w_wr_hit[k] = 1'b0;
            w_wr_val[k] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            if (we[j]) begin
                w_wr_hit[wa[j*ADDR_W +: ADDR_W]] = 1'b1;
                w_wr_val[wa[j*ADDR_W +: ADDR_W]] = wd[j*DATA_W +: DATA_W];
            end
        end
        w_wr_hit[0] = 1'b0;
    end

    // Issue set is applied after write clears so it wins on the same register.
    always_comb begin : busy_next
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j]) begin
                    w_busy_nxt[wa[j*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (iss_valid) begin
                w_busy_nxt[iss_rd] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < c_NREG; k++) begin
                r_regs[k] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int k = 0; k < c_NREG; k++) begin
                if (w_wr_hit[k]) begin
                    r_regs[k] <= w_wr_val[k];
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

    // r0 is never written, so a plain array lookup already reads zero for it.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_ra = ra[i*ADDR_W +: ADDR_W];

`ifdef RF_WR_BYPASS_EN
        always_comb begin
            w_data = r_regs[w_ra];
            w_busy = r_busy[w_ra];
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*ADDR_W +: ADDR_W] == w_ra) && (w_ra != '0)) begin
                    w_data = wd[j*DATA_W +: DATA_W];
                    w_busy = 1'b0;
                end
            end
        end
`else
        assign w_data = r_regs[w_ra];
        assign w_busy = r_busy[w_ra];
`endif

        assign rd_data[i*DATA_W +: DATA_W] = w_data;
        assign rd_busy[i]                  = w_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp_sb
//  Description : Self-checking bench for regfile_mp_sb against an array model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_mp_sb;

    localparam int c_DW   = 32;
    localparam int c_AW   = 5;
    localparam int c_NRD  = 2;
    localparam int c_NWR  = 2;
    localparam int c_NREG = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [c_NRD*c_AW-1:0]  ra;
    logic [c_NRD*c_DW-1:0]  rd_data;
    logic [c_NRD-1:0]       rd_busy;
    logic [c_NWR-1:0]       we;
    logic [c_NWR*c_AW-1:0]  wa;
    logic [c_NWR*c_DW-1:0]  wd;
    logic                   iss_valid;
    logic [c_AW-1:0]        iss_rd;
    logic                   flush;
    logic [c_NREG-1:0]      busy_vec;

    int checks = 0;
    int errors = 0;

    logic [c_DW-1:0]   m_reg [c_NREG];
    logic [c_NREG-1:0] m_busy;

    regfile_mp_sb #(.DATA_W(c_DW), .ADDR_W(c_AW), .NRD(c_NRD), .NWR(c_NWR)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .flush(flush), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < c_NREG; k++) m_reg[k] = '0;
        m_busy = '0;
    endtask

    task automatic set_idle();
        we = '0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    // Expected read: stored value, optionally overridden by a same-cycle write.
    task automatic check_outputs(input string tag);
        for (int i = 0; i < c_NRD; i++) begin
            logic [c_AW-1:0] a;
            logic [c_DW-1:0] ed;
            logic            eb;
            a  = ra[i*c_AW +: c_AW];
            ed = (a == 0) ? '0 : m_reg[a];
            eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef RF_WR_BYPASS_EN
            for (int j = 0; j < c_NWR; j++) begin
                if (a != 0 && we[j] && wa[j*c_AW +: c_AW] == a) begin
                    ed = wd[j*c_DW +: c_DW];
                    eb = 1'b0;
                end
            end
`endif
            check({tag, "_data"}, 64'(rd_data[i*c_DW +: c_DW]), 64'(ed));
            check({tag, "_rdbusy"}, 64'(rd_busy[i]), 64'(eb));
        end
        check({tag, "_busyvec"}, 64'(busy_vec), 64'(m_busy));
    endtask

    // Check current outputs, apply the clock-edge rules to the model, then clock.
    task automatic step(input string tag);
        logic [c_NREG-1:0] nb;
        #1;
        check_outputs(tag);
        for (int j = 0; j < c_NWR; j++)
            if (we[j] && wa[j*c_AW +: c_AW] != 0)
                m_reg[wa[j*c_AW +: c_AW]] = wd[j*c_DW +: c_DW];
        nb = m_busy;
        if (flush) nb = '0;
        else begin
            for (int j = 0; j < c_NWR; j++)
                if (we[j] && wa[j*c_AW +: c_AW] != 0) nb[wa[j*c_AW +: c_AW]] = 1'b0;
            if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
        end
        m_busy = nb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        ra = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset_busyvec0", 64'(busy_vec), 64'h0);
        rst_n = 1'b1;

        // r0 writes and issues are ignored
        we = 2'b01; wa[4:0] = 5'd0; wd[31:0] = 32'h1234;
        iss_valid = 1'b1; iss_rd = 5'd0; ra = '0;
        step("r0_in");
        set_idle();
        #1;
        check("r0_data", 64'(rd_data[31:0]), 64'h0);
        check("r0_busy", 64'(busy_vec[0]), 64'h0);

        // highest write port wins
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h0000_000B, 32'h0000_000A};
        step("prio_in");
        set_idle();
        ra[4:0] = 5'd7;
        #1;
        check("prio_r7", 64'(rd_data[31:0]), 64'hB);

        // scoreboard set / clear / set-beats-clear
        iss_valid = 1'b1; iss_rd = 5'd3;
        step("sb_iss");
        set_idle();
        ra = {5'd3, 5'd3};
        #1;
        check("sb_vec3", 64'(busy_vec[3]), 64'h1);
        check("sb_rdbusy3", 64'(rd_busy[0]), 64'h1);
        we = 2'b01; wa[4:0] = 5'd3; wd[31:0] = 32'h55;
        step("sb_wr");
        set_idle();
        #1;
        check("sb_clr_vec3", 64'(busy_vec[3]), 64'h0);
        check("sb_clr_data", 64'(rd_data[31:0]), 64'h55);
        iss_valid = 1'b1; iss_rd = 5'd3;
        we = 2'b10; wa[9:5] = 5'd3; wd[63:32] = 32'h66;
        step("sb_both");
        set_idle();
        #1;
        check("sb_both_vec3", 64'(busy_vec[3]), 64'h1);
        check("sb_both_data", 64'(rd_data[31:0]), 64'h66);
        we = 2'b01; wa[4:0] = 5'd3; wd[31:0] = 32'h66;
        step("sb_release");
        set_idle();

        // flush clears everything and drops the same-cycle issue
        iss_valid = 1'b1; iss_rd = 5'd1; step("fl_i1");
        iss_rd = 5'd2; step("fl_i2");
        iss_rd = 5'd9; step("fl_i9");
        set_idle();
        #1;
        check("flush_pre", 64'(busy_vec), 64'h0000_0206);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
        step("flush_in");
        set_idle();
        ra[4:0] = 5'd4;
        #1;
        check("flush_vec", 64'(busy_vec), 64'h0);
        check("flush_r4", 64'(rd_busy[0]), 64'h0);

        // write-to-read on a busy register
        iss_valid = 1'b1; iss_rd = 5'd6;
        step("byp_iss");
        set_idle();
        we = 2'b01; wa[4:0] = 5'd6; wd[31:0] = 32'h77; ra[9:5] = 5'd6;
        #1;
`ifdef RF_WR_BYPASS_EN
        check("byp_data_now", 64'(rd_data[63:32]), 64'h77);
        check("byp_busy_now", 64'(rd_busy[1]), 64'h0);
`else
        check("byp_data_now", 64'(rd_data[63:32]), 64'h0);
        check("byp_busy_now", 64'(rd_busy[1]), 64'h1);
`endif
        step("byp_wr");
        set_idle();
        #1;
        check("byp_data_next", 64'(rd_data[63:32]), 64'h77);
        check("byp_busy_next", 64'(rd_busy[1]), 64'h0);

        // asynchronous reset mid-cycle
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hDEADBEEF;
        iss_valid = 1'b1; iss_rd = 5'd8;
        step("rst_wr");
        set_idle();
        ra[4:0] = 5'd5;
        #1;
        check("rst_pre", 64'(rd_data[31:0]), 64'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_data", 64'(rd_data[31:0]), 64'h0);
        check("rst_vec", 64'(busy_vec), 64'h0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'h11;
        step("cold_wr");
        set_idle();
        #1;
        check("cold_r5", 64'(rd_data[31:0]), 64'h11);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            we        = c_NWR'($urandom);
            wa        = (c_NWR*c_AW)'($urandom);
            wd        = {$urandom, $urandom};
            ra        = (c_NRD*c_AW)'($urandom);
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_rd    = c_AW'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            step("rand");
        end
        set_idle();
        step("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
